// File: rtl/dmem_arbiter.sv
// Two-port load/store arbiter and sequencer for the byte-addressed data memory.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default is fixed priority).
module dmem_arbiter #(
  parameter int PC_WIDTH = 32,
  parameter int DATA_W   = 32,
  parameter int STORE_M  = 2,
  parameter int M_STACK  = 1024
) (
  input  logic                clk,
  input  logic                n_rst,

  input  logic                rq0_valid,
  output logic                rq0_ready,
  input  logic                rq0_we,
  input  logic [PC_WIDTH-1:0] rq0_addr,
  input  logic [2:0]          rq0_mode,
  input  logic [DATA_W-1:0]   rq0_wdata,
  output logic                rq0_rvalid,
  output logic [DATA_W-1:0]   rq0_rdata,
  output logic                rq0_err,

  input  logic                rq1_valid,
  output logic                rq1_ready,
  input  logic                rq1_we,
  input  logic [PC_WIDTH-1:0] rq1_addr,
  input  logic [2:0]          rq1_mode,
  input  logic [DATA_W-1:0]   rq1_wdata,
  output logic                rq1_rvalid,
  output logic [DATA_W-1:0]   rq1_rdata,
  output logic                rq1_err,

  output logic                m_wr_en,
  output logic [PC_WIDTH-1:0] m_rd_addr,
  output logic [PC_WIDTH-1:0] m_wr_addr,
  output logic [STORE_M-1:0]  m_mode,
  output logic [DATA_W-1:0]   m_d_in,
  input  logic [DATA_W-1:0]   m_d_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_id;
  logic                r_we;
  logic [PC_WIDTH-1:0] r_addr;
  logic [2:0]          r_mode;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic                r_wr_en;
  logic                r_rvalid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rsp_err;

  logic                w_pick1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_sel_we;
  logic [PC_WIDTH-1:0] w_sel_addr;
  logic [2:0]          w_sel_mode;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [2:0]          w_size_m1;
  logic [PC_WIDTH:0]   w_end;
  logic                w_illegal;
  logic                w_misalign;
  logic                w_oor;
  logic                w_err;
  logic [DATA_W-1:0]   w_ext;

`ifdef DMEM_ARB_RR_EN
  logic r_rr;
  // r_rr names the requester preferred when both are valid
  assign w_pick1 = rq1_valid & (~rq0_valid | r_rr);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rr <= 1'b0;
    end else if (w_accept) begin
      r_rr <= ~w_pick1;
    end
  end
`else
  assign w_pick1 = rq1_valid & ~rq0_valid;
`endif

  assign w_gnt1   = w_pick1;
  assign w_gnt0   = rq0_valid & ~w_pick1;
  assign w_accept = (r_state == ST_IDLE) & (w_gnt0 | w_gnt1);

  // ready is gated by reset so every output reads 0 while n_rst is low
  assign rq0_ready = n_rst & (r_state == ST_IDLE) & w_gnt0;
  assign rq1_ready = n_rst & (r_state == ST_IDLE) & w_gnt1;

  assign w_sel_we    = w_pick1 ? rq1_we    : rq0_we;
  assign w_sel_addr  = w_pick1 ? rq1_addr  : rq0_addr;
  assign w_sel_mode  = w_pick1 ? rq1_mode  : rq0_mode;
  assign w_sel_wdata = w_pick1 ? rq1_wdata : rq0_wdata;

  always_comb begin
    w_size_m1 = 3'd0;
    case (w_sel_mode[1:0])
      2'b01:   w_size_m1 = 3'd1;
      2'b10:   w_size_m1 = 3'd3;
      default: w_size_m1 = 3'd0;
    endcase
  end

  // one extra bit so an address that wraps past 2^PC_WIDTH still fails the bound
  assign w_end = {1'b0, w_sel_addr} + (PC_WIDTH+1)'(w_size_m1);
  assign w_oor = (w_end >= (PC_WIDTH+1)'(M_STACK));

  assign w_illegal  = (w_sel_mode == 3'b011) | (w_sel_mode == 3'b110) |
                      (w_sel_mode == 3'b111) | (w_sel_we & w_sel_mode[2]);
  assign w_misalign = ((w_sel_mode[1:0] == 2'b01) & w_sel_addr[0]) |
                      ((w_sel_mode[1:0] == 2'b10) & (w_sel_addr[1:0] != 2'b00));
  assign w_err      = w_illegal | w_misalign | w_oor;

  always_comb begin
    w_ext = m_d_out;
    case (r_mode)
      3'b000:  w_ext = {{(DATA_W-8){m_d_out[7]}},   m_d_out[7:0]};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}},         m_d_out[7:0]};
      3'b001:  w_ext = {{(DATA_W-16){m_d_out[15]}}, m_d_out[15:0]};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}},        m_d_out[15:0]};
      default: w_ext = m_d_out;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_id      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_mode    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rsp_id  <= 1'b0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rvalid <= 1'b0;
          if (w_accept) begin
            r_id    <= w_pick1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_mode  <= w_sel_mode;
            r_wdata <= w_sel_wdata;
            r_err   <= w_err;
            r_wr_en <= w_sel_we & ~w_err;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_wr_en   <= 1'b0;
          r_rvalid  <= 1'b1;
          r_rsp_id  <= r_id;
          r_rsp_err <= r_err;
          r_rdata   <= (r_we | r_err) ? '0 : w_ext;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          r_rvalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_wr_en  <= 1'b0;
          r_rvalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_wr_en   = r_wr_en;
  assign m_rd_addr = r_addr;
  assign m_wr_addr = r_addr;
  assign m_mode    = r_mode[STORE_M-1:0];
  assign m_d_in    = r_wdata;

  assign rq0_rvalid = r_rvalid & ~r_rsp_id;
  assign rq1_rvalid = r_rvalid &  r_rsp_id;
  assign rq0_rdata  = r_rsp_id ? '0 : r_rdata;
  assign rq1_rdata  = r_rsp_id ? r_rdata : '0;
  assign rq0_err    = r_rsp_err & ~r_rsp_id;
  assign rq1_err    = r_rsp_err &  r_rsp_id;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model behind the memory port.
`define CHK(tag, obs, exp) \
  begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        n_rst;
  logic        rq0_valid, rq0_ready, rq0_we, rq0_rvalid, rq0_err;
  logic [31:0] rq0_addr, rq0_wdata, rq0_rdata;
  logic [2:0]  rq0_mode;
  logic        rq1_valid, rq1_ready, rq1_we, rq1_rvalid, rq1_err;
  logic [31:0] rq1_addr, rq1_wdata, rq1_rdata;
  logic [2:0]  rq1_mode;
  logic        m_wr_en;
  logic [31:0] m_rd_addr, m_wr_addr, m_d_in, m_d_out;
  logic [1:0]  m_mode;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:1023];

  logic        o_wr, o_rv, o_er, o_rv2, o_orv;
  logic [31:0] o_waddr, o_din, o_rd, o_ord;
  logic [1:0]  o_mode;

  int grants [4];
  int exp_g  [4];
  int ng, busy;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
    .rq0_mode(rq0_mode), .rq0_wdata(rq0_wdata), .rq0_rvalid(rq0_rvalid),
    .rq0_rdata(rq0_rdata), .rq0_err(rq0_err),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
    .rq1_mode(rq1_mode), .rq1_wdata(rq1_wdata), .rq1_rvalid(rq1_rvalid),
    .rq1_rdata(rq1_rdata), .rq1_err(rq1_err),
    .m_wr_en(m_wr_en), .m_rd_addr(m_rd_addr), .m_wr_addr(m_wr_addr),
    .m_mode(m_mode), .m_d_in(m_d_in), .m_d_out(m_d_out)
  );

  always @(posedge clk) begin : mem_wr
    int nb;
    if (m_wr_en) begin
      nb = (m_mode == 2'b00) ? 1 : (m_mode == 2'b01) ? 2 : 4;
      for (int k = 0; k < nb; k++)
        if (m_wr_addr + k < 1024) mem[m_wr_addr + k] <= m_d_in[8*k +: 8];
    end
  end

  always_comb begin
    m_d_out = '0;
    for (int k = 0; k < 4; k++)
      if (m_rd_addr + k < 1024) m_d_out[8*k +: 8] = mem[m_rd_addr + k];
  end

  task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                        input logic [2:0] mode, input logic [31:0] wd);
    bit ok;
    ok = 0;
    if (p == 0) begin
      rq0_valid = 1; rq0_we = we; rq0_addr = addr; rq0_mode = mode; rq0_wdata = wd;
    end else begin
      rq1_valid = 1; rq1_we = we; rq1_addr = addr; rq1_mode = mode; rq1_wdata = wd;
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      if ((p == 0) ? rq0_ready : rq1_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $error("FAIL ready_timeout: observed=0 expected=1 (port %0d)", p);
      rq0_valid = 0; rq1_valid = 0;
      o_wr = 1'bx; o_rv = 1'bx; o_er = 1'bx; o_rv2 = 1'bx; o_rd = 'x;
      return;
    end
    @(posedge clk); #1;
    rq0_valid = 0; rq1_valid = 0;
    @(negedge clk);
    o_wr = m_wr_en; o_waddr = m_wr_addr; o_mode = m_mode; o_din = m_d_in;
    @(negedge clk);
    o_rv  = (p == 0) ? rq0_rvalid : rq1_rvalid;
    o_rd  = (p == 0) ? rq0_rdata  : rq1_rdata;
    o_er  = (p == 0) ? rq0_err    : rq1_err;
    o_orv = (p == 0) ? rq1_rvalid : rq0_rvalid;
    o_ord = (p == 0) ? rq1_rdata  : rq0_rdata;
    @(negedge clk);
    o_rv2 = (p == 0) ? rq0_rvalid : rq1_rvalid;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rq0_valid = 0; rq0_we = 0; rq0_addr = 0; rq0_mode = 0; rq0_wdata = 0;
    rq1_valid = 0; rq1_we = 0; rq1_addr = 0; rq1_mode = 0; rq1_wdata = 0;
    n_rst = 0;
    rq0_valid = 1;
    #2;
    `CHK("rst_ready", rq0_ready, 1'b0)
    `CHK("rst_wr_en", m_wr_en, 1'b0)
    `CHK("rst_rvalid", rq0_rvalid, 1'b0)
    `CHK("rst_rdata", rq0_rdata, 32'h0)
    `CHK("rst_wr_addr", m_wr_addr, 32'h0)
    rq0_valid = 0;
    @(negedge clk); n_rst = 1;
    @(negedge clk);

    // store word, then read it back on both ports
    do_req(0, 1, 32'h10, 3'b010, 32'hDEADBEEF);
    `CHK("sw_wr_en", o_wr, 1'b1)
    `CHK("sw_wr_addr", o_waddr, 32'h10)
    `CHK("sw_mode", o_mode, 2'b10)
    `CHK("sw_d_in", o_din, 32'hDEADBEEF)
    `CHK("sw_rvalid", o_rv, 1'b1)
    `CHK("sw_err", o_er, 1'b0)
    `CHK("sw_rdata", o_rd, 32'h0)
    `CHK("sw_rvalid_1cyc", o_rv2, 1'b0)
    do_req(0, 0, 32'h10, 3'b010, 32'h0);
    `CHK("lw0_wr_en", o_wr, 1'b0)
    `CHK("lw0_rdata", o_rd, 32'hDEADBEEF)
    `CHK("lw0_err", o_er, 1'b0)
    do_req(1, 0, 32'h10, 3'b010, 32'h0);
    `CHK("lw1_rvalid", o_rv, 1'b1)
    `CHK("lw1_rdata", o_rd, 32'hDEADBEEF)
    `CHK("lw1_other_rvalid", o_orv, 1'b0)
    `CHK("lw1_other_rdata", o_ord, 32'h0)

    // byte stores then each load extension
    do_req(0, 1, 32'h14, 3'b000, 32'h00000080);
    `CHK("sb14_wr_en", o_wr, 1'b1)
    `CHK("sb14_mode", o_mode, 2'b00)
    do_req(0, 1, 32'h15, 3'b000, 32'h000000FF);
    do_req(0, 0, 32'h14, 3'b000, 32'h0);
    `CHK("lb", o_rd, 32'hFFFFFF80)
    do_req(0, 0, 32'h14, 3'b100, 32'h0);
    `CHK("lbu", o_rd, 32'h00000080)
    do_req(0, 0, 32'h14, 3'b001, 32'h0);
    `CHK("lh", o_rd, 32'hFFFFFF80)
    do_req(0, 0, 32'h14, 3'b101, 32'h0);
    `CHK("lhu", o_rd, 32'h0000FF80)
    do_req(0, 0, 32'h14, 3'b010, 32'h0);
    `CHK("lw14", o_rd, 32'h0000FF80)

    // error cases
    do_req(0, 0, 32'h12, 3'b010, 32'h0);
    `CHK("lw_mis_err", o_er, 1'b1)
    `CHK("lw_mis_rdata", o_rd, 32'h0)
    `CHK("lw_mis_rvalid", o_rv, 1'b1)
    do_req(0, 1, 32'h11, 3'b001, 32'h00001234);
    `CHK("sh_mis_err", o_er, 1'b1)
    `CHK("sh_mis_wr_en", o_wr, 1'b0)
    `CHK("sh_mis_mem", {mem[8'h12], mem[8'h11], mem[8'h10]}, 24'hADBEEF)
    do_req(0, 1, 32'd1022, 3'b010, 32'h11111111);
    `CHK("sw_oor_err", o_er, 1'b1)
    `CHK("sw_oor_wr_en", o_wr, 1'b0)
    do_req(0, 0, 32'h10, 3'b011, 32'h0);
    `CHK("mode011_err", o_er, 1'b1)
    do_req(0, 1, 32'h20, 3'b100, 32'h55);
    `CHK("sbu_store_err", o_er, 1'b1)
    `CHK("sbu_store_wr_en", o_wr, 1'b0)
    do_req(0, 0, 32'd1023, 3'b000, 32'h0);
    `CHK("lb_last_err", o_er, 1'b0)
    do_req(0, 0, 32'd1023, 3'b001, 32'h0);
    `CHK("lh_last_err", o_er, 1'b1)
    do_req(0, 0, 32'hFFFFFFFC, 3'b010, 32'h0);
    `CHK("lw_wrap_err", o_er, 1'b1)

    // reset during the ACCESS cycle of a store
    rq0_valid = 1; rq0_we = 1; rq0_addr = 32'h40; rq0_mode = 3'b010; rq0_wdata = 32'h12345678;
    #1;
    `CHK("midrst_ready", rq0_ready, 1'b1)
    @(posedge clk); #1;
    rq0_valid = 0;
    `CHK("midrst_wr_en_pre", m_wr_en, 1'b1)
    #1; n_rst = 0; #1;
    `CHK("midrst_wr_en", m_wr_en, 1'b0)
    `CHK("midrst_wr_addr", m_wr_addr, 32'h0)
    `CHK("midrst_d_in", m_d_in, 32'h0)
    `CHK("midrst_rvalid", rq0_rvalid, 1'b0)
    @(posedge clk);
    @(negedge clk); n_rst = 1;
    @(negedge clk);
    `CHK("midrst_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0)
    rq0_valid = 1; rq0_we = 0; rq0_addr = 32'h10; rq0_mode = 3'b010;
    #1;
    `CHK("postrst_ready", rq0_ready, 1'b1)
    rq0_valid = 0;

    // contention: both valid until four grants are seen
`ifdef DMEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    @(negedge clk);
    rq0_valid = 1; rq0_we = 0; rq0_addr = 32'h10; rq0_mode = 3'b010;
    rq1_valid = 1; rq1_we = 0; rq1_addr = 32'h14; rq1_mode = 3'b010;
    ng = 0; busy = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      #1;
      `CHK("one_ready", rq0_ready & rq1_ready, 1'b0)
      if (busy > 0) begin
        `CHK("ready_idle_only", rq0_ready | rq1_ready, 1'b0)
        busy--;
      end else if (rq0_ready || rq1_ready) begin
        grants[ng] = rq1_ready ? 1 : 0;
        ng++;
        busy = 2;
      end
      if (ng < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rq0_valid = 0; rq1_valid = 0;
    `CHK("grant_count", ng, 4)
    for (int g = 0; g < 4; g++) begin
      if (g < ng) `CHK("grant_seq", grants[g], exp_g[g])
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
